jpeg_inbuf: RTL and testbench
=============================

# jpeg_inbuf

Double-buffered input block buffer between the JPEG DMA engine and the DCT stage. The DMA writes one 8x8 block of 8-bit pixels as 16 big-endian 32-bit words into the fill bank. A start pulse swaps banks and streams the block out as eight 64-bit rows over a valid/ready handshake. Its busy flag is the DMA's `dct_busy`, which gates software's next-block command.

## Interface
Parameters:
- none

Ports:
- `clk_i`  in  1  system clock; all state changes on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `wr_data_i`  in  32  pixel word; bits 31:24 = leftmost pixel
- `wr_addr_i`  in  9  byte address from DMA; bits [5:2] = word index w, others ignored
- `wr_en_i`  in  1  write strobe, one word per cycle
- `start_i`  in  1  single-cycle pulse: block in fill bank complete, begin output
- `busy_o`  out  1  block being streamed; drives DMA `dct_busy`
- `row_data_o`  out  64  one pixel row, pixel 0 in bits 63:56
- `row_idx_o`  out  3  row number 0..7 of `row_data_o`
- `row_last_o`  out  1  high with `row_valid_o` when `row_idx_o` = 7
- `row_valid_o`  out  1  `row_data_o` valid
- `row_ready_i`  in  1  DCT accepts row when high with `row_valid_o`
- `fill_bank_o`  out  1  bank currently receiving writes
- `overrun_o`  out  1  sticky: `start_i` seen while busy

## Operation
- Storage: two banks, 8 rows x 64 bits each, synchronous read (1-cycle latency).
- Write mapping: row = w[3:1], half = w[0]; half 0 -> bits 63:32, half 1 -> bits 31:0.
- Writes always target the fill bank, never the read bank.
- FSM states:
  - `IDLE`: `busy_o`=0. On `start_i`, read bank := fill bank, fill bank toggles, row counter := 0, go to `LOAD`.
  - `LOAD`: present row counter as RAM address, go to `OUT`.
  - `OUT`: register RAM data into `row_data_o`, assert `row_valid_o`, hold until `row_ready_i`=1.
    - On handshake with row < 7: row++, go to `LOAD`.
    - On handshake with row = 7: go to `IDLE`.
- `busy_o` = 1 in `LOAD` and `OUT`.
- `row_data_o`, `row_idx_o` and `row_last_o` stay stable while `row_valid_o` is high and `row_ready_i` is low.
- `start_i` outside `IDLE`: ignored, no bank swap, `overrun_o` set to 1. `overrun_o` is cleared only by reset.
- `wr_en_i` and `start_i` in the same cycle: the write lands in the old fill bank, which becomes the read bank. The word is therefore part of the block being output.
- A partially written block (fewer than 16 words) is still output; unwritten words carry stale bank contents.

## Timing
- Reset values: `busy_o`=0, `row_valid_o`=0, `row_data_o`=0, `row_idx_o`=0, `row_last_o`=0, `fill_bank_o`=0, `overrun_o`=0, state `IDLE`.
- RAM contents are not cleared by reset.
- Reset mid-block aborts streaming; all outputs take reset values on the cycle after `rst_i` is sampled.
- `start_i` sampled at edge N:
  - `busy_o`=1 and `fill_bank_o` toggled from N+1.
  - `row_valid_o`=1 with row 0 from N+2.
- Row handshake at edge M: `row_valid_o`=0 in M+1, next row valid from M+2. Maximum rate is one row per 2 cycles; a block takes at least 16 cycles.
- Handshake on row 7 at edge M: `busy_o`=0 from M+1. A new `start_i` is accepted at M+1.
- A write at edge N is readable by a block started at edge N or later.

## Configuration
- `JPEG_INBUF_LEVELSHIFT_EN` defined: each output byte has its MSB inverted. This gives the two's-complement value (pixel - 128) expected by the DCT; e.g. 0x00 -> 0x80, 0xFF -> 0x7F.
- Macro undefined: raw unsigned bytes are output unchanged; level shift is done downstream.
- Storage and write path are identical in both builds.

## Test plan
- Write words w=0..15 with data 0x00010203 + 0x04040404*w, then pulse `start_i` with `row_ready_i`=1 -> 8 rows, row 0 at N+2, one row every 2 cycles, `row_last_o` on row 7, `busy_o` drops the cycle after.
  - Without macro: row 0 = 0x0001020304050607.
  - With macro: row 0 = 0x8081828384858687.
- Ready backpressure: hold `row_ready_i`=0 for 5 cycles on row 3 -> `row_data_o` and `row_idx_o`=3 stable; row 4 appears 2 cycles after `row_ready_i` rises.
- Double buffering: during streaming of block A, write block B (all 0xAAAAAAAA) to the fill bank -> block A output uncorrupted; a second start after `busy_o` falls outputs 0xAAAA...AA rows; `fill_bank_o` toggles on each start.
- Pulse `start_i` while `busy_o`=1 -> no bank swap, current block completes normally, `overrun_o`=1 and remains 1 until reset.
- Assert `rst_i` during row 5 of a block -> next cycle all outputs zero and state `IDLE`; a subsequent start outputs the current fill-bank contents from row 0.
- Write w=15 in the same cycle as `start_i` -> row 7 low half equals that word.

Source files
------------

// File: rtl/jpeg_inbuf_if.sv
// Handshake and bus bundle between the DMA/DCT side and jpeg_inbuf.
// The slave modport is the buffer's view; master is the DMA/DCT driver view.
interface jpeg_inbuf_if;
    logic [31:0] wr_data_i;
    logic [8:0]  wr_addr_i;
    logic        wr_en_i;
    logic        start_i;
    logic        busy_o;
    logic [63:0] row_data_o;
    logic [2:0]  row_idx_o;
    logic        row_last_o;
    logic        row_valid_o;
    logic        row_ready_i;
    logic        fill_bank_o;
    logic        overrun_o;

    modport slave (
        input  wr_data_i, wr_addr_i, wr_en_i, start_i, row_ready_i,
        output busy_o, row_data_o, row_idx_o, row_last_o, row_valid_o,
        output fill_bank_o, overrun_o
    );

    modport master (
        output wr_data_i, wr_addr_i, wr_en_i, start_i, row_ready_i,
        input  busy_o, row_data_o, row_idx_o, row_last_o, row_valid_o,
        input  fill_bank_o, overrun_o
    );
endinterface

// File: rtl/jpeg_inbuf.sv
// Double-buffered 8x8 pixel block buffer feeding the DCT one 64-bit row at a time.
// Define JPEG_INBUF_LEVELSHIFT_EN to output (pixel - 128) by inverting each byte MSB.
module jpeg_inbuf (
    input  logic         clk_i,
    input  logic         rst_i,
    jpeg_inbuf_if.slave  bus
);

`ifdef JPEG_INBUF_LEVELSHIFT_EN
    localparam logic [63:0] SHIFT_MASK = {8{8'h80}};
`else
    localparam logic [63:0] SHIFT_MASK = 64'h0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

    state_t      state;
    logic        read_bank;
    logic [2:0]  row_cnt;
    logic [63:0] mem [16];

    logic unused_addr;
    assign unused_addr = ^{bus.wr_addr_i[8:6], bus.wr_addr_i[1:0]};

    // Writes always hit the current fill bank; on a same-cycle start this is the
    // bank about to become the read bank, so the word joins the outgoing block.
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i) begin
            if (bus.wr_addr_i[2])
                mem[{bus.fill_bank_o, bus.wr_addr_i[5:3]}][31:0]  <= bus.wr_data_i;
            else
                mem[{bus.fill_bank_o, bus.wr_addr_i[5:3]}][63:32] <= bus.wr_data_i;
        end
    end

    // The RAM read issued in LOAD lands straight in row_data_o, so the output
    // register doubles as the synchronous read register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            read_bank       <= 1'b0;
            row_cnt         <= 3'd0;
            bus.busy_o      <= 1'b0;
            bus.row_data_o  <= 64'h0;
            bus.row_idx_o   <= 3'd0;
            bus.row_last_o  <= 1'b0;
            bus.row_valid_o <= 1'b0;
            bus.fill_bank_o <= 1'b0;
            bus.overrun_o   <= 1'b0;
        end else begin
            if (bus.start_i && state != IDLE)
                bus.overrun_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        read_bank       <= bus.fill_bank_o;
                        bus.fill_bank_o <= ~bus.fill_bank_o;
                        row_cnt         <= 3'd0;
                        bus.busy_o      <= 1'b1;
                        state           <= LOAD;
                    end
                end
                LOAD: begin
                    bus.row_data_o  <= mem[{read_bank, row_cnt}] ^ SHIFT_MASK;
                    bus.row_idx_o   <= row_cnt;
                    bus.row_last_o  <= (row_cnt == 3'd7);
                    bus.row_valid_o <= 1'b1;
                    state           <= OUT;
                end
                OUT: begin
                    if (bus.row_ready_i) begin
                        bus.row_valid_o <= 1'b0;
                        if (row_cnt == 3'd7) begin
                            bus.busy_o <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + 3'd1;
                            state   <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_inbuf.sv
// Directed self-checking bench for jpeg_inbuf; follows JPEG_INBUF_LEVELSHIFT_EN
// so the same expectations hold in both builds.
module tb_jpeg_inbuf;

`ifdef JPEG_INBUF_LEVELSHIFT_EN
    localparam logic [63:0] SHIFT_MASK = {8{8'h80}};
`else
    localparam logic [63:0] SHIFT_MASK = 64'h0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic expFill;
    logic [63:0] expRow [8];

    jpeg_inbuf_if bus ();

    jpeg_inbuf dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pixWord(input int w);
        return 32'h00010203 + 32'h04040404 * 32'(w);
    endfunction

    task automatic applyStimulus(input logic [8:0] addr, input logic [31:0] data);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = addr;
        bus.wr_data_i = data;
        stepCycle();
        bus.wr_en_i   = 1'b0;
    endtask

    // Odd words also set ignored address bits to show they play no part.
    task automatic writePattern();
        for (int w = 0; w < 16; w++)
            applyStimulus(9'(w << 2) | ((w % 2 == 1) ? 9'h143 : 9'h000), pixWord(w));
    endtask

    task automatic setPatternRows();
        for (int r = 0; r < 8; r++)
            expRow[r] = {pixWord(2 * r), pixWord(2 * r + 1)} ^ SHIFT_MASK;
    endtask

    task automatic setFlatRows(input logic [31:0] word);
        for (int r = 0; r < 8; r++)
            expRow[r] = {word, word} ^ SHIFT_MASK;
    endtask

    task automatic startBlock(input string tag);
        bus.start_i = 1'b1;
        stepCycle();
        bus.start_i = 1'b0;
        expFill = ~expFill;
        checkOutput({tag, "_fill"}, 64'(bus.fill_bank_o), 64'(expFill));
    endtask

    // Called right after the start edge; checks exact row timing with ready high,
    // an optional stall on one row, and an optional stray start on one row.
    task automatic streamBlock(input string tag, input int stallRow, input int stallCycles,
                               input int overrunRow);
        checkOutput({tag, "_busy_on"}, 64'(bus.busy_o), 64'd1);
        checkOutput({tag, "_valid_pre"}, 64'(bus.row_valid_o), 64'd0);
        for (int r = 0; r < 8; r++) begin
            stepCycle();
            checkOutput($sformatf("%s_r%0d_valid", tag, r), 64'(bus.row_valid_o), 64'd1);
            checkOutput($sformatf("%s_r%0d_idx", tag, r), 64'(bus.row_idx_o), 64'(r));
            checkOutput($sformatf("%s_r%0d_data", tag, r), bus.row_data_o, expRow[r]);
            checkOutput($sformatf("%s_r%0d_last", tag, r), 64'(bus.row_last_o), 64'(r == 7));
            if (r == stallRow) begin
                bus.row_ready_i = 1'b0;
                for (int k = 0; k < stallCycles; k++) begin
                    stepCycle();
                    checkOutput($sformatf("%s_stall%0d_valid", tag, k), 64'(bus.row_valid_o), 64'd1);
                    checkOutput($sformatf("%s_stall%0d_idx", tag, k), 64'(bus.row_idx_o), 64'(r));
                    checkOutput($sformatf("%s_stall%0d_data", tag, k), bus.row_data_o, expRow[r]);
                end
                bus.row_ready_i = 1'b1;
            end
            if (r == overrunRow)
                bus.start_i = 1'b1;
            stepCycle();
            bus.start_i = 1'b0;
            checkOutput($sformatf("%s_r%0d_gap", tag, r), 64'(bus.row_valid_o), 64'd0);
            if (r == overrunRow) begin
                checkOutput({tag, "_overrun"}, 64'(bus.overrun_o), 64'd1);
                checkOutput({tag, "_noswap"}, 64'(bus.fill_bank_o), 64'(expFill));
            end
        end
        checkOutput({tag, "_busy_off"}, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic writeFlatBlock(input logic [31:0] word);
        for (int w = 0; w < 16; w++)
            applyStimulus(9'(w << 2), word);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        expFill         = 1'b0;
        bus.wr_en_i     = 1'b0;
        bus.wr_addr_i   = 9'h0;
        bus.wr_data_i   = 32'h0;
        bus.start_i     = 1'b0;
        bus.row_ready_i = 1'b1;
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;

        checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
        checkOutput("rst_valid", 64'(bus.row_valid_o), 64'd0);
        checkOutput("rst_data", bus.row_data_o, 64'h0);
        checkOutput("rst_idx", 64'(bus.row_idx_o), 64'd0);
        checkOutput("rst_last", 64'(bus.row_last_o), 64'd0);
        checkOutput("rst_fill", 64'(bus.fill_bank_o), 64'd0);
        checkOutput("rst_overrun", 64'(bus.overrun_o), 64'd0);

        // Basic block out of bank 0.
        writePattern();
        setPatternRows();
        checkOutput("basic_row0_const", expRow[0] ^ SHIFT_MASK, 64'h0001020304050607);
        startBlock("basic");
        streamBlock("basic", -1, 0, -1);

        // Backpressure on row 3, block out of bank 1.
        writePattern();
        startBlock("stall");
        streamBlock("stall", 3, 5, -1);

        // Bank 0 still holds the pattern; fill bank 1 with 0xAA while it streams.
        startBlock("dbufA");
        fork
            streamBlock("dbufA", -1, 0, -1);
            writeFlatBlock(32'hAAAAAAAA);
        join
        setFlatRows(32'hAAAAAAAA);
        startBlock("dbufB");
        streamBlock("dbufB", -1, 0, -1);

        // Stray start mid-block: bank 0 pattern again.
        setPatternRows();
        startBlock("ovr");
        streamBlock("ovr", -1, 0, 2);
        stepCycle();
        stepCycle();
        checkOutput("ovr_sticky", 64'(bus.overrun_o), 64'd1);
        checkOutput("ovr_fill_after", 64'(bus.fill_bank_o), 64'(expFill));

        // Reset during row 5 of a bank-1 block.
        setFlatRows(32'hAAAAAAAA);
        startBlock("rstmid");
        for (int k = 0; k < 11; k++)
            stepCycle();
        checkOutput("rstmid_r5_idx", 64'(bus.row_idx_o), 64'd5);
        checkOutput("rstmid_r5_valid", 64'(bus.row_valid_o), 64'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("rstmid_busy", 64'(bus.busy_o), 64'd0);
        checkOutput("rstmid_valid", 64'(bus.row_valid_o), 64'd0);
        checkOutput("rstmid_data", bus.row_data_o, 64'h0);
        checkOutput("rstmid_idx", 64'(bus.row_idx_o), 64'd0);
        checkOutput("rstmid_last", 64'(bus.row_last_o), 64'd0);
        checkOutput("rstmid_fill", 64'(bus.fill_bank_o), 64'd0);
        checkOutput("rstmid_overrun", 64'(bus.overrun_o), 64'd0);
        expFill = 1'b0;
        stepCycle();
        setPatternRows();
        startBlock("postrst");
        streamBlock("postrst", -1, 0, -1);

        // Write of word 15 in the start cycle lands in the outgoing bank 1.
        setFlatRows(32'hAAAAAAAA);
        expRow[7] = {32'hAAAAAAAA, 32'h12345678} ^ SHIFT_MASK;
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 9'h03C;
        bus.wr_data_i = 32'h12345678;
        startBlock("samecyc");
        bus.wr_en_i   = 1'b0;
        streamBlock("samecyc", -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
